// File: rtl/multicycle_control.sv
// Multicycle processor control FSM: fetch/decode/execute/memory/writeback sequencing
// with a wait-timeout watchdog on instruction and data memory handshakes.
module multicycle_control #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALU_W    = 3,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                instr_valid,
  input  logic                mem_ready,
  input  logic                resume,
  output logic [2:0]          state,
  output logic                pc_write,
  output logic                ir_write,
  output logic                mem_req,
  output logic                mem_write,
  output logic                regWriteEnable,
  output logic                imm_Control_6,
  output logic                imm_Control_3,
  output logic                jump,
  output logic                branch,
  output logic                halted,
  output logic                err,
  output logic [ALU_W-1:0]    aluControl
);

  localparam int unsigned CntW = $clog2(WAIT_MAX + 1);

  localparam logic [3:0] OpHalt = 4'd0;
  localparam logic [3:0] OpAdd  = 4'd1;
  localparam logic [3:0] OpSub  = 4'd2;
  localparam logic [3:0] OpAnd  = 4'd3;
  localparam logic [3:0] OpOr   = 4'd4;
  localparam logic [3:0] OpXor  = 4'd5;
  localparam logic [3:0] OpAddi = 4'd6;
  localparam logic [3:0] OpSubi = 4'd7;
  localparam logic [3:0] OpSlli = 4'd8;
  localparam logic [3:0] OpSrli = 4'd9;
  localparam logic [3:0] OpJal  = 4'd10;
  localparam logic [3:0] OpJalr = 4'd11;
  localparam logic [3:0] OpLw   = 4'd12;
  localparam logic [3:0] OpSw   = 4'd13;
  localparam logic [3:0] OpBeq  = 4'd14;
  localparam logic [3:0] OpBge  = 4'd15;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                err_q, err_d;

  logic [3:0] op4;
  logic [2:0] alu_dec;
  logic       imm6_dec, imm3_dec, is_jmp, is_br, is_mem, is_sw;
  logic       op_big, wait_done;

  assign op4       = op_q[3:0];
  assign op_big    = (32'(opcode) >= 32'd16);
  // Timeout fires on the WAIT_MAX-th consecutive wait cycle.
  assign wait_done = (32'(cnt_q) >= WAIT_MAX - 32'd1);

  // Instruction class decode, driven only by the registered opcode.
  always_comb begin
    alu_dec  = 3'b000;
    imm6_dec = 1'b0;
    imm3_dec = 1'b0;
    is_jmp   = 1'b0;
    is_br    = 1'b0;
    is_mem   = 1'b0;
    is_sw    = 1'b0;
    case (op4)
      OpHalt, OpAdd: ;
      OpSub:  alu_dec = 3'b001;
      OpAnd:  alu_dec = 3'b010;
      OpOr:   alu_dec = 3'b011;
      OpXor:  alu_dec = 3'b100;
      OpAddi: imm6_dec = 1'b1;
      OpSubi: begin alu_dec = 3'b001; imm6_dec = 1'b1; end
      OpSlli: begin alu_dec = 3'b101; imm6_dec = 1'b1; end
      OpSrli: begin alu_dec = 3'b110; imm6_dec = 1'b1; end
      OpJal, OpJalr: begin imm6_dec = 1'b1; is_jmp = 1'b1; end
      OpLw:   begin imm6_dec = 1'b1; is_mem = 1'b1; end
      OpSw:   begin imm6_dec = 1'b1; is_mem = 1'b1; is_sw = 1'b1; end
      OpBeq, OpBge: begin imm3_dec = 1'b1; is_br = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    pc_write       = 1'b0;
    ir_write       = 1'b0;
    mem_req        = 1'b0;
    mem_write      = 1'b0;
    regWriteEnable = 1'b0;
    imm_Control_6  = 1'b0;
    imm_Control_3  = 1'b0;
    jump           = 1'b0;
    branch         = 1'b0;
    halted         = 1'b0;
    aluControl     = '0;

    if (state_q inside {StExec, StMem, StWb}) begin
      aluControl    = ALU_W'(alu_dec);
      imm_Control_6 = imm6_dec;
      imm_Control_3 = imm3_dec;
    end

    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (instr_valid) begin
          ir_write = 1'b1;
          state_d  = StDecode;
        end else if (wait_done) begin
          state_d = StHalt;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDecode: begin
        op_d = opcode;
        if (op_big) begin
          state_d = StHalt;
          err_d   = 1'b1;
        end else if (opcode == '0) begin
          state_d = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        branch   = is_br;
        jump     = is_jmp;
        pc_write = is_br;
        if (is_br)       state_d = StFetch;
        else if (is_mem) state_d = StMem;
        else             state_d = StWb;
      end
      StMem: begin
        mem_req   = 1'b1;
        mem_write = is_sw;
        if (mem_ready) begin
          pc_write = is_sw;
          state_d  = is_sw ? StFetch : StWb;
        end else if (wait_done) begin
          state_d = StHalt;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWb: begin
        regWriteEnable = 1'b1;
        pc_write       = 1'b1;
        jump           = is_jmp;
        state_d        = StFetch;
      end
      StHalt: begin
        halted = 1'b1;
        if (resume) begin
          err_d   = 1'b0;
          state_d = StFetch;
        end
      end
      default: begin
        state_d = StHalt;
        err_d   = 1'b1;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      op_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign state = state_q;
  assign err   = err_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: an instruction-level model expands each instruction into its expected
// per-cycle output trace, which a single compare process checks against the DUT.
module tb_multicycle_control;

  localparam int WaitMax = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic       instr_valid = 1'b0, mem_ready = 1'b0, resume = 1'b0;
  logic [2:0] state;
  logic       pc_write, ir_write, mem_req, mem_write, regWriteEnable;
  logic       imm_Control_6, imm_Control_3, jump, branch, halted, err;
  logic [2:0] aluControl;

  multicycle_control #(
    .OPCODE_W(4),
    .ALU_W   (3),
    .WAIT_MAX(WaitMax)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .instr_valid   (instr_valid),
    .mem_ready     (mem_ready),
    .resume        (resume),
    .state         (state),
    .pc_write      (pc_write),
    .ir_write      (ir_write),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .regWriteEnable(regWriteEnable),
    .imm_Control_6 (imm_Control_6),
    .imm_Control_3 (imm_Control_3),
    .jump          (jump),
    .branch        (branch),
    .halted        (halted),
    .err           (err),
    .aluControl    (aluControl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, iv, mr, res;
    logic [3:0] op;
    logic [2:0] st;
    logic       pcw, irw, mreq, mwr, rwe, i6, i3, jmp, br, hlt, err;
    logic [2:0] alu;
  } cyc_t;

  cyc_t q[$];
  cyc_t cur;
  bit   cur_valid = 1'b0;
  int   cyc_idx = 0;
  int   checks = 0, errors = 0;
  bit   tie = 1'b0;
  bit   m_err = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h want %0h", name, cyc_idx, act, exp);
    end
  endtask

  // Spec decode tables, keyed by mnemonic opcode value.
  function automatic logic [2:0] alu_of(input logic [3:0] op);
    case (op)
      4'd2, 4'd7: return 3'd1;
      4'd3:       return 3'd2;
      4'd4:       return 3'd3;
      4'd5:       return 3'd4;
      4'd8:       return 3'd5;
      4'd9:       return 3'd6;
      default:    return 3'd0;
    endcase
  endfunction

  function automatic logic imm6_of(input logic [3:0] op);
    return op inside {4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13};
  endfunction

  function automatic cyc_t base(input logic [2:0] st);
    cyc_t c;
    c.rst = 1'b0; c.iv = tie; c.mr = tie; c.res = 1'b0;
    c.op  = 4'($urandom);
    c.st  = st;
    c.pcw = 0; c.irw = 0; c.mreq = 0; c.mwr = 0; c.rwe = 0;
    c.i6  = 0; c.i3 = 0; c.jmp = 0; c.br = 0; c.alu = 3'd0;
    c.hlt = (st == 3'd5);
    c.err = (st == 3'd5) ? m_err : 1'b0;
    return c;
  endfunction

  // Expand one instruction into its expected cycles. rst_mem >= 0 pulses reset on that
  // MEM wait cycle and abandons the instruction.
  task automatic do_instr(input logic [3:0] op, input int fw, input int mw, input int rst_mem);
    cyc_t c;
    bit is_sw, is_lw, is_br, is_j;
    is_lw = (op == 4'd12);
    is_sw = (op == 4'd13);
    is_br = (op == 4'd14) || (op == 4'd15);
    is_j  = (op == 4'd10) || (op == 4'd11);
    for (int i = 0; i < fw && i < WaitMax; i++) begin
      c = base(3'd0); c.iv = 1'b0; c.mreq = 1'b1; q.push_back(c);
    end
    if (fw >= WaitMax) begin m_err = 1'b1; return; end
    c = base(3'd0); c.iv = 1'b1; c.mreq = 1'b1; c.irw = 1'b1; q.push_back(c);
    c = base(3'd1); c.op = op; q.push_back(c);
    if (op == 4'd0) return;
    c = base(3'd2); c.alu = alu_of(op); c.i6 = imm6_of(op); c.i3 = is_br;
    c.br = is_br; c.pcw = is_br; c.jmp = is_j; q.push_back(c);
    if (is_br) return;
    if (is_lw || is_sw) begin
      for (int i = 0; i < mw && i < WaitMax; i++) begin
        c = base(3'd3); c.alu = alu_of(op); c.i6 = 1'b1; c.mreq = 1'b1; c.mwr = is_sw;
        c.mr = 1'b0;
        if (i == rst_mem) begin
          c.rst = 1'b1; q.push_back(c); m_err = 1'b0; return;
        end
        q.push_back(c);
      end
      if (mw >= WaitMax) begin m_err = 1'b1; return; end
      c = base(3'd3); c.alu = alu_of(op); c.i6 = 1'b1; c.mreq = 1'b1; c.mwr = is_sw;
      c.mr = 1'b1; c.pcw = is_sw; q.push_back(c);
      if (is_sw) return;
    end
    c = base(3'd4); c.alu = alu_of(op); c.i6 = imm6_of(op); c.rwe = 1'b1; c.pcw = 1'b1;
    c.jmp = is_j; q.push_back(c);
  endtask

  task automatic halt_hold(input int n, input bit by_reset);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = base(3'd5); q.push_back(c);
    end
    c = base(3'd5);
    if (by_reset) c.rst = 1'b1;
    else          c.res = 1'b1;
    q.push_back(c);
    m_err = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cur_valid) begin
      chk("state", 8'(state), 8'(cur.st));
      chk("pc_write", 8'(pc_write), 8'(cur.pcw));
      chk("ir_write", 8'(ir_write), 8'(cur.irw));
      chk("mem_req", 8'(mem_req), 8'(cur.mreq));
      chk("mem_write", 8'(mem_write), 8'(cur.mwr));
      chk("regWriteEnable", 8'(regWriteEnable), 8'(cur.rwe));
      chk("imm6", 8'(imm_Control_6), 8'(cur.i6));
      chk("imm3", 8'(imm_Control_3), 8'(cur.i3));
      chk("jump", 8'(jump), 8'(cur.jmp));
      chk("branch", 8'(branch), 8'(cur.br));
      chk("halted", 8'(halted), 8'(cur.hlt));
      chk("err", 8'(err), 8'(cur.err));
      chk("aluControl", 8'(aluControl), 8'(cur.alu));
    end
  end

  initial begin
    int s;
    int n;
    logic [2:0] add_seq [4];
    add_seq = '{3'd0, 3'd1, 3'd2, 3'd4};

    // Build the expected trace, pinning the model against hand-computed literals.
    tie = 1'b0;
    do_instr(4'd2, 2, 0, -1);
    chk("pin_reset_state", 8'(q[0].st), 8'd0);
    chk("pin_reset_memreq", 8'(q[0].mreq), 8'd1);

    tie = 1'b1;
    s = q.size();
    do_instr(4'd1, 0, 0, -1);
    chk("pin_add_latency", 8'(q.size() - s), 8'd4);
    for (int k = 0; k < 4; k++) chk("pin_add_state", 8'(q[s+k].st), 8'(add_seq[k]));
    chk("pin_add_rwe_wb", 8'(q[s+3].rwe), 8'd1);
    chk("pin_add_rwe_exec", 8'(q[s+2].rwe), 8'd0);

    tie = 1'b0;
    s = q.size();
    do_instr(4'd12, 0, 3, -1);
    n = 0;
    for (int k = s; k < q.size(); k++) if (q[k].st == 3'd3) n++;
    chk("pin_lw_mem_cycles", 8'(n), 8'd4);
    chk("pin_lw_last_wb", 8'(q[q.size()-1].rwe), 8'd1);

    s = q.size();
    do_instr(4'd13, 0, 0, -1);
    chk("pin_sw_latency", 8'(q.size() - s), 8'd4);

    s = q.size();
    do_instr(4'd14, 0, 0, -1);
    chk("pin_beq_latency", 8'(q.size() - s), 8'd3);
    chk("pin_beq_imm3", 8'(q[s+2].i3), 8'd1);
    chk("pin_beq_branch", 8'(q[s+2].br), 8'd1);

    do_instr(4'd13, 10, 10, -1);  // waits in two states must not accumulate
    do_instr(4'd15, 1, 0, -1);
    do_instr(4'd10, 0, 0, -1);
    do_instr(4'd11, 3, 0, -1);
    do_instr(4'd3, 0, 0, -1);
    do_instr(4'd4, 0, 0, -1);
    do_instr(4'd5, 0, 0, -1);
    do_instr(4'd6, 0, 0, -1);
    do_instr(4'd7, 0, 0, -1);
    do_instr(4'd8, 0, 0, -1);
    do_instr(4'd9, 14, 0, -1);
    do_instr(4'd12, 0, 14, -1);

    do_instr(4'd0, 0, 0, -1);
    halt_hold(10, 1'b0);
    do_instr(4'd13, 0, 15, -1);
    chk("pin_sw_timeout_err", 8'(m_err), 8'd1);
    halt_hold(3, 1'b0);
    do_instr(4'd1, 15, 0, -1);
    halt_hold(2, 1'b1);
    do_instr(4'd13, 0, 5, 2);
    do_instr(4'd1, 0, 0, -1);
    do_instr(4'd2, 0, 0, -1);

    // Drive the trace.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < q.size(); i++) begin
      cur         = q[i];
      cyc_idx     = i;
      reset       = cur.rst;
      opcode      = cur.op;
      instr_valid = cur.iv;
      mem_ready   = cur.mr;
      resume      = cur.res;
      cur_valid   = 1'b1;
      @(posedge clk);
      #1;
    end
    cur_valid = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter OPCODE_W, default 4, meaning opcode width; it must be at least 4.
REQ-002 SHALL have parameter ALU_W, default 3, meaning aluControl width; it must be at least 3.
REQ-003 SHALL have parameter WAIT_MAX, default 15, meaning the maximum number of cycles to wait for instr_valid or mem_ready before a timeout.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port opcode, input, OPCODE_W bits: instruction opcode, sampled only in DECODE.
REQ-007 SHALL have port instr_valid, input, 1 bit: instruction memory data ready.
REQ-008 SHALL have port mem_ready, input, 1 bit: data memory access complete.
REQ-009 SHALL have port resume, input, 1 bit: leave HALT.
REQ-010 SHALL have outputs state (3 bits), pc_write, ir_write, mem_req, mem_write, regWriteEnable, imm_Control_6, imm_Control_3, jump, branch, halted and err (1 bit each), and aluControl (ALU_W bits).

Function
REQ-011 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and HALT=5, exposed on state; encodings 6 and 7 SHALL go to HALT with err=1.
REQ-012 In FETCH: mem_req=1; on instr_valid, ir_write=1 for that cycle, then go to DECODE; otherwise stay in FETCH.
REQ-013 In DECODE: register opcode into op_q, then go to EXEC. Opcode 0 (halt) SHALL go to HALT with no register write. An opcode value of 16 or more SHALL go to HALT with err=1.
REQ-014 Decode table for aluControl:
- add, addi, jal, jalr, lw, sw, beq, bge: 000
- sub, subi: 001
- and: 010
- or: 011
- xor: 100
- slli: 101
- srli: 110
REQ-015 Immediate select:
- imm_Control_6=1 for addi, jalr, slli, srli, subi, jal, lw, sw
- imm_Control_3=1 for beq, bge
- never both set at once
REQ-016 In EXEC:
- lw or sw: go to MEM
- beq, bge: branch=1, pc_write=1, go to FETCH
- jal, jalr: jump=1, go to WB
- all others: go to WB
REQ-017 In MEM: mem_req=1, and mem_write=1 only for sw. On mem_ready, lw goes to WB; sw asserts pc_write=1 and goes to FETCH.
REQ-018 In WB: regWriteEnable=1 and pc_write=1 for exactly one cycle, and jump stays asserted for jal/jalr; then go to FETCH.
REQ-019 regWriteEnable SHALL be 1 only in WB; it is never asserted for halt, sw, beq or bge.
REQ-020 Wait counter:
- counts consecutive cycles in FETCH with instr_valid=0, or in MEM with mem_ready=0
- clears on any state change
- on reaching WAIT_MAX: go to HALT, err=1, drop mem_req
REQ-021 In HALT: halted=1 and all strobes are 0. A resume pulse clears err, clears the counter and goes to FETCH; otherwise stay in HALT.
REQ-022 Timing: aluControl, immediate selects, jump and branch are decoded from op_q and state only, never directly from opcode. Zero-wait latencies:
- R-type / I-type ALU: 4 cycles
- lw: 5 cycles
- sw: 4 cycles
- branch: 3 cycles

Reset
REQ-023 Reset SHALL win over every other input on the same edge, including mid-MEM or mid-wait.
REQ-024 After reset:
- state=FETCH, op_q=0, counter=0, err=0, halted=0
- all strobes and aluControl are 0
- mem_req=1 from the first cycle after reset
REQ-025 A reset asserted during MEM for sw SHALL ensure mem_write=0 in the following cycle.

Verification
REQ-026 add (0001), instr_valid and mem_ready tied to 1 -> state sequence 0,1,2,4,0; regWriteEnable=1 only in cycle 4; aluControl=000.
REQ-027 lw (1100), mem_ready delayed 3 cycles -> MEM held for 4 cycles with mem_req=1 and mem_write=0, then WB with regWriteEnable=1.
REQ-028 beq (1110) -> branch=1, pc_write=1, imm_Control_3=1 in EXEC; regWriteEnable never 1; next state FETCH.
REQ-029 halt (0000) -> HALT with halted=1 and err=0, held 10 cycles; a resume pulse -> FETCH next cycle.
REQ-030 mem_ready held at 0 for sw with WAIT_MAX=15 -> HALT with err=1 after 15 wait cycles, with mem_req=0 from then on.
REQ-031 reset asserted in MEM during sw -> next cycle state=0, mem_write=0, err=0, all outputs at their reset values.
